// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a first-word-fall-through FIFO and emits start/data/parity/stop.
// Latency: fifo_pop, tx (start bit) and tsre change on the edge after IDLE sees en=1 with a non-empty FIFO.
// Backpressure: pops only when en=1 and the FIFO is non-empty; en gates new frames, never an active one.
module uart_tx_engine #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       set_break,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tsre
);

    // The tick counter must reach 2*OVERSAMPLE-1 to time a two-bit stop period in one pass.
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_ONE    = TW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_n;
    logic [TW-1:0] tick_q, tick_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shreg_q, shreg_n;
    logic [1:0]    wls_q, wls_n;
    logic          stb_q, stb_n;
    logic          pen_q, pen_n;
    logic          par_q, par_n;
    logic          tx_q, tx_n;
    logic          tsre_q, tsre_n;
    logic          pop_q, pop_n;

    logic          load;
    logic          bit_end;
    logic          stop_end;
    logic [TW-1:0] stop_last;
    logic [7:0]    data_mask;
    logic          data_xor;
    logic          par_load;
    logic          tx_fsm;

    // Stop length comes from the frozen frame config, not the live LCR inputs.
    always_comb begin
        stop_last = BIT_LAST;
        if (stb_q) begin
            stop_last = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
        end
    end

    // Parity of the incoming byte is resolved at load time, masked to the selected word length.
    always_comb begin
        data_mask = 8'hFF;
        case (wls)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        data_xor = ^(fifo_dout & data_mask);
        par_load = sp ? ~eps : (eps ? data_xor : ~data_xor);
    end

    // Next-state, counters, shift register and registered-output values.
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        bit_n    = bit_q;
        shreg_n  = shreg_q;
        wls_n    = wls_q;
        stb_n    = stb_q;
        pen_n    = pen_q;
        par_n    = par_q;
        load     = 1'b0;
        bit_end  = baud_pulse && (tick_q == BIT_LAST);
        stop_end = baud_pulse && (tick_q == stop_last);

        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tick_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else if (baud_pulse) begin
                    tick_n = tick_q + TICK_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_n  = '0;
                    shreg_n = {1'b0, shreg_q[7:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                        state_n = pen_q ? PARITY : STOP;
                    end
                end else if (baud_pulse) begin
                    tick_n = tick_q + TICK_ONE;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tick_n  = '0;
                    state_n = STOP;
                end else if (baud_pulse) begin
                    tick_n = tick_q + TICK_ONE;
                end
            end
            STOP: begin
                if (stop_end) begin
                    tick_n = '0;
                    if (en && !fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (baud_pulse) begin
                    tick_n = tick_q + TICK_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A load restarts the frame regardless of where it came from; a tick in this cycle is dropped.
        if (load) begin
            state_n = START;
            tick_n  = '0;
            bit_n   = 3'd0;
            shreg_n = fifo_dout;
            wls_n   = wls;
            stb_n   = stb;
            pen_n   = pen;
            par_n   = par_load;
        end

        tx_fsm = 1'b1;
        case (state_n)
            START:   tx_fsm = 1'b0;
            DATA:    tx_fsm = shreg_n[0];
            PARITY:  tx_fsm = par_n;
            default: tx_fsm = 1'b1;
        endcase

        tx_n   = tx_fsm & ~set_break;
        tsre_n = (state_n == IDLE);
        pop_n  = load;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            wls_q   <= 2'b00;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            tsre_q  <= 1'b1;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            wls_q   <= wls_n;
            stb_q   <= stb_n;
            pen_q   <= pen_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            tsre_q  <= tsre_n;
            pop_q   <= pop_n;
        end
    end

    assign fifo_pop = pop_q;
    assign tx       = tx_q;
    assign tsre     = tsre_q;

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit serializer for the 16550A-compatible UART. It drains bytes from the TX FIFO read port (pop/dout/empty) and shifts each one out on the serial line as start bit, 5-8 data bits LSB-first, optional parity, and 1/1.5/2 stop bits. Bit timing comes from the shared 16x baud tick. The LCR fields are applied per frame.

## Interface
Parameters:
- OVERSAMPLE, 16, baud ticks per bit. Must be even and at least 4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- baud_pulse  in  1  one-clk-wide tick at 16x the bit rate
- en  in  1  transmit enable. Gates the start of new frames only.
- fifo_empty  in  1  TX FIFO empty flag
- fifo_dout  in  8  TX FIFO head byte. Valid whenever fifo_empty=0 (first-word fall-through).
- wls  in  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- stb  in  1  stop bits: 0 gives 1; 1 gives 2, or 1.5 when wls=00
- pen  in  1  parity enable
- eps  in  1  even parity select
- sp  in  1  stick parity
- set_break  in  1  forces tx low
- fifo_pop  out  1  one-clk pop strobe to the TX FIFO
- tx  out  1  serial output; idle high
- tsre  out  1  shift register empty: 1 when the engine is in IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - tx=1, tsre=1.
  - If en=1 and fifo_empty=0: assert fifo_pop for exactly one cycle. On the same edge, latch fifo_dout into shreg, and latch wls/stb/pen/eps/sp into frame config registers. Next state is START with tick_cnt=0.
- Tick counting: tick_cnt increments only on cycles with baud_pulse=1. A bit ends on the baud_pulse that brings tick_cnt to OVERSAMPLE-1; tick_cnt then wraps to 0.
- START: tx=0 for one bit, then DATA with bit_cnt=0.
- DATA
  - tx=shreg[0]. At each bit end, shift shreg right and increment bit_cnt.
  - After 5+wls bits, go to PARITY if pen=1, else STOP.
- PARITY: tx is one bit wide.
  - sp=1: tx=~eps.
  - sp=0, eps=1: tx = XOR of the data bits.
  - sp=0, eps=0: tx = XNOR of the data bits.
  - Only the 5+wls transmitted bits are included; unused high bits are masked.
- STOP: tx=1. Length is OVERSAMPLE ticks (1 stop), 2*OVERSAMPLE (2 stop), or 3*OVERSAMPLE/2 (1.5 stop, stb=1 with wls=00).
- End of STOP:
  - If en=1 and fifo_empty=0: pop and latch on that same edge and go directly to START (back-to-back frames, no idle bit).
  - Otherwise go to IDLE.
- Frame config is frozen at load. LCR changes mid-frame apply to the next frame.
- set_break=1 forces tx=0 combinationally from registered state. The FSM keeps running and FIFO draining continues. When set_break drops, tx follows the FSM on the next cycle.
- en=0 mid-frame: the current frame completes, and no further pops occur.
- fifo_pop is never asserted while fifo_empty=1. No underrun can be generated by this block.

## Timing
- Reset values (rst=0 at an edge): state=IDLE, tx=1, tsre=1, fifo_pop=0, tick_cnt=0, bit_cnt=0, shreg=0.
- Reset mid-frame aborts the frame. tx=1 from the next edge on.
- tx, tsre, and fifo_pop are registered outputs. The tx=1 forced by reset is included.
- Pop latency: fifo_pop rises on the edge after the cycle in which IDLE sees en=1 and fifo_empty=0. tx falls on that same edge (START).
- Start bit edge jitter is at most one baud_pulse period, because tick phase is not reset.
- Frame length in ticks is OVERSAMPLE × (1 + data bits + pen + stop bits).
  - Example: 8N1 = 160 ticks.
  - Example: 5E1.5 = 16×(1+5+1+1.5) = 136 ticks.
- tsre falls with the pop edge. It rises on the edge after STOP ends with no pending byte.
- baud_pulse arriving in the pop/load cycle is not counted.

## Test plan
- Single byte: load 0x55 as 8N1 with the baud divider at 4 clk/tick. Required: one pop; tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 64 clks; tsre=1 after 640 clks.
- Back-to-back: push 0xA3 and 0x0F as 8E2. Required: parity bits 0 then 0; two stop bits; second start bit immediately after stop; exactly 2 pops; no idle gap.
- Width and parity: load 0x3F with wls=00 (5-bit), pen=1, eps=0, stb=1. Required: data bits 1,1,1,1,1; parity 0 (odd); stop lasts 24 ticks. Repeat with sp=1, eps=1: parity bit is 0.
- Empty FIFO and en=0: with fifo_empty=1, no pop and tx held at 1. Drop en mid-frame while 3 bytes are queued: the current frame finishes and no pop follows.
- Break: assert set_break for 50 ticks during DATA. Required: tx=0 throughout; the frame still completes and 1 pop occurs. tx returns to FSM value one clk after release.
- Reset mid-frame: rst=0 during DATA bit 3. Required: next edge gives tx=1, tsre=1, fifo_pop=0; the following byte transmits correctly after rst=1.
